// File: rtl/fas_pkg.sv
// Shared definitions for the FAS signal chain: sizing helper, round/saturate
// helper and default parameters common to the FIR front end and FFT collector.
package fas_pkg;

    localparam int unsigned FAS_FRAME  = 16;
    localparam int unsigned FAS_DATA_W = 16;

    typedef struct packed {
        logic signed [63:0] val;
        logic               ovf;
    } fas_rs_t;

    // Ceiling log2, never below 1 so it can size a port directly.
    function automatic int unsigned fas_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Half-up rounding by s fractional bits, then clip to a signed out_w range.
    function automatic fas_rs_t fas_round_sat(input logic signed [63:0] acc,
                                              input int unsigned s,
                                              input int unsigned out_w);
        fas_rs_t            res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (s - 1))) >>> s;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        res.val = r;
        res.ovf = 1'b0;
        if (r > hi) begin
            res.val = hi;
            res.ovf = 1'b1;
        end else if (r < lo) begin
            res.val = lo;
            res.ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac_tree.sv
// Sum of NP signed products, registered once. Products and the adder
// reduction are combinational; the single register stage carries a valid.
module fir_mac_tree
    import fas_pkg::*;
#(
    parameter int unsigned NP    = 32,
    parameter int unsigned A_W   = 16,
    parameter int unsigned B_W   = 20,
    parameter int unsigned ACC_W = 41
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic signed [A_W-1:0]   i_a [NP],
    input  logic signed [B_W-1:0]   i_b [NP],
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] o_sum
);

    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_sum;
    logic                    r_valid;

    // Full-precision dot product; ACC_W is wide enough that nothing wraps.
    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            w_sum = w_sum + ACC_W'(i_a[k]) * ACC_W'(i_b[k]);
        end
    end

    // Pipeline register; clear drops whatever sum is in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) r_sum <= w_sum;
        end
    end

    assign o_valid = r_valid;
    assign o_sum   = r_sum;

endmodule

// File: rtl/fir_stream_engine.sv
// Streaming FIR front end: delay line, run-time coefficient RAM, fill
// counter, 2-cycle valid pipeline, round/saturate and FFT frame indexing.
module fir_stream_engine
    import fas_pkg::*;
#(
    parameter int unsigned TAPS      = 32,
    parameter int unsigned SYM       = 0,
    parameter int unsigned DATA_W    = FAS_DATA_W,
    parameter int unsigned DATA_FRAC = 8,
    parameter int unsigned COEF_W    = 20,
    parameter int unsigned COEF_FRAC = 16,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned OUT_FRAC  = 8,
    parameter int unsigned FRAME     = FAS_FRAME
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                clear,
    input  logic                                                data_valid,
    input  logic signed [DATA_W-1:0]                            data,
    input  logic                                                coef_we,
    input  logic [fas_clog2((SYM != 0) ? TAPS / 2 : TAPS)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0]                            coef_wdata,
    output logic                                                fir_valid,
    output logic signed [OUT_W-1:0]                             fir_d,
    output logic [fas_clog2(FRAME)-1:0]                         frame_idx,
    output logic                                                frame_last,
    output logic                                                ovf
);

    localparam int unsigned NC     = (SYM != 0) ? TAPS / 2 : TAPS;
    localparam int unsigned FI_W   = fas_clog2(FRAME);
    localparam int unsigned FILL_W = fas_clog2(TAPS);
    localparam int unsigned A_W    = DATA_W + ((SYM != 0) ? 1 : 0);
    localparam int unsigned ACC_W  = DATA_W + COEF_W + fas_clog2(TAPS);
    localparam int unsigned S      = DATA_FRAC + COEF_FRAC - OUT_FRAC;

    logic signed [DATA_W-1:0] r_dl [TAPS];
    logic signed [COEF_W-1:0] r_coef [NC];
    logic [FILL_W-1:0]        r_fill;
    logic                     r_v0;
    logic signed [A_W-1:0]    w_a [NC];
    logic                     w_mac_valid;
    logic signed [ACC_W-1:0]  w_sum;
    fas_rs_t                  w_rs;
    logic                     w_full;
    logic                     w_unused;

    logic                     r_valid;
    logic signed [OUT_W-1:0]  r_d;
    logic                     r_ovf;
    logic [FI_W-1:0]          r_fidx;
    logic                     r_last;
    logic [FI_W-1:0]          r_fcnt;

    assign w_full = (r_fill == FILL_W'(TAPS - 1));

    // Delay line and fill count; r_v0 marks a shift that completes a window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < TAPS; k++) r_dl[k] <= '0;
            r_fill <= '0;
            r_v0   <= 1'b0;
        end else if (clear) begin
            for (int unsigned k = 0; k < TAPS; k++) r_dl[k] <= '0;
            r_fill <= '0;
            r_v0   <= 1'b0;
        end else begin
            r_v0 <= data_valid && w_full;
            if (data_valid) begin
                r_dl[0] <= data;
                for (int unsigned k = 1; k < TAPS; k++) r_dl[k] <= r_dl[k-1];
                if (!w_full) r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Coefficient RAM; out-of-range addresses are ignored, clear keeps contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NC; k++) r_coef[k] <= '0;
        end else if (coef_we && (int'(coef_addr) < int'(NC))) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    generate
        if (SYM != 0) begin : g_sym
            // Fold mirrored taps so only NC multipliers are needed.
            always_comb begin
                for (int unsigned k = 0; k < NC; k++) begin
                    w_a[k] = A_W'(r_dl[k]) + A_W'(r_dl[TAPS-1-k]);
                end
            end
        end else begin : g_full
            // One multiplier operand per tap.
            always_comb begin
                for (int unsigned k = 0; k < NC; k++) begin
                    w_a[k] = A_W'(r_dl[k]);
                end
            end
        end
    endgenerate

    fir_mac_tree #(
        .NP   (NC),
        .A_W  (A_W),
        .B_W  (COEF_W),
        .ACC_W(ACC_W)
    ) u_mac (
        .i_clk  (clk),
        .i_rst_n(rst),
        .i_clear(clear),
        .i_valid(r_v0),
        .i_a    (w_a),
        .i_b    (r_coef),
        .o_valid(w_mac_valid),
        .o_sum  (w_sum)
    );

    // Rescale the registered sum to the output format.
    always_comb begin
        w_rs = fas_round_sat(64'(w_sum), S, OUT_W);
    end

    assign w_unused = ^w_rs.val[63:OUT_W];

    // Output stage: data and frame index hold between results, flags pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            r_ovf   <= 1'b0;
            r_fidx  <= '0;
            r_last  <= 1'b0;
            r_fcnt  <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_fidx  <= '0;
            r_last  <= 1'b0;
            r_fcnt  <= '0;
        end else if (w_mac_valid) begin
            r_valid <= 1'b1;
            r_d     <= w_rs.val[OUT_W-1:0];
            r_ovf   <= w_rs.ovf;
            r_fidx  <= r_fcnt;
            r_last  <= (r_fcnt == FI_W'(FRAME - 1));
            r_fcnt  <= r_fcnt + 1'b1;
        end else begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign fir_valid  = r_valid;
    assign fir_d      = r_d;
    assign ovf        = r_ovf;
    assign frame_idx  = r_fidx;
    assign frame_last = r_last;

endmodule

// File: tb/tb_fir_stream_engine.sv
// Scoreboard bench for fir_stream_engine: a default instance and a SYM=1
// instance share the sample stream; a behavioural model pushes expected results.
module tb_fir_stream_engine;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        data_valid;
    logic [15:0] data;
    logic        coef_we;
    logic        coef_we_s;
    logic [4:0]  coef_addr;
    logic [3:0]  coef_addr_s;
    logic [19:0] coef_wdata;

    logic        fv0, fl0, ov0, fv1, fl1, ov1;
    logic [15:0] fd0, fd1;
    logic [3:0]  fi0, fi1;

    fir_stream_engine u_dut (
        .clk(clk), .rst(rst), .clear(clear), .data_valid(data_valid), .data(data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .fir_valid(fv0), .fir_d(fd0), .frame_idx(fi0), .frame_last(fl0), .ovf(ov0)
    );

    fir_stream_engine #(.SYM(1)) u_sym (
        .clk(clk), .rst(rst), .clear(clear), .data_valid(data_valid), .data(data),
        .coef_we(coef_we_s), .coef_addr(coef_addr_s), .coef_wdata(coef_wdata),
        .fir_valid(fv1), .fir_d(fd1), .frame_idx(fi1), .frame_last(fl1), .ovf(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        bit          ov;
        int          fi;
        bit          fl;
        int          t;
    } rec_t;

    rec_t   expq[$];
    rec_t   obs0[$];
    rec_t   obs1[$];
    longint mc[32];
    longint hist[32];
    int     nacc;
    int     fcnt;
    int     cyc;
    int     checks;
    int     fails;

    task automatic model_zero_state();
        for (int k = 0; k < 32; k++) hist[k] = 0;
        nacc = 0;
        fcnt = 0;
    endtask

    // One clock: drive inputs, update the reference model, record DUT outputs.
    task automatic step(input bit dv, input logic [15:0] d, input bit clr);
        longint y;
        rec_t   e;
        data_valid = dv;
        data       = d;
        clear      = clr;
        @(posedge clk);
        cyc++;
        if (clr) begin
            while (expq.size() > 0 && expq[$].t >= cyc - 2) void'(expq.pop_back());
            model_zero_state();
        end else if (dv) begin
            for (int k = 31; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = longint'($signed(d));
            if (nacc >= 31) begin
                y = 0;
                for (int k = 0; k < 32; k++) y += mc[k] * hist[k];
                y = (y + 64'sd32768) >>> 16;
                e.ov = 1'b0;
                if (y > 32767) begin y = 32767; e.ov = 1'b1; end
                if (y < -32768) begin y = -32768; e.ov = 1'b1; end
                e.d  = 16'(y);
                e.fi = fcnt % 16;
                e.fl = (fcnt % 16) == 15;
                e.t  = cyc;
                expq.push_back(e);
                fcnt++;
            end
            nacc++;
        end
        #1;
        if (fv0) obs0.push_back('{fd0, ov0, int'(fi0), fl0, cyc});
        if (fv1) obs1.push_back('{fd1, ov1, int'(fi1), fl1, cyc});
        data_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic wr(input bit sel_s, input int addr, input int val);
        coef_wdata = 20'(val);
        if (sel_s) begin
            coef_we_s   = 1'b1;
            coef_addr_s = 4'(addr);
        end else begin
            coef_we   = 1'b1;
            coef_addr = 5'(addr);
        end
        @(posedge clk);
        cyc++;
        #1;
        coef_we   = 1'b0;
        coef_we_s = 1'b0;
    endtask

    task automatic load0(input int addr, input int val);
        wr(1'b0, addr, val);
        mc[addr] = longint'(val);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data_valid = 1'b1;
        data = 16'h1234;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fv0 !== 1'b0 || fd0 !== 16'h0 || ov0 !== 1'b0 || fi0 !== 4'h0 || fl0 !== 1'b0) begin
                fails++;
                $display("FAIL reset_out got v=%0b d=%h ovf=%0b idx=%0d last=%0b want all 0", fv0, fd0, ov0, fi0, fl0);
            end
            checks++;
            if (fv1 !== 1'b0 || fd1 !== 16'h0 || ov1 !== 1'b0 || fi1 !== 4'h0 || fl1 !== 1'b0) begin
                fails++;
                $display("FAIL reset_out_sym got v=%0b d=%h ovf=%0b idx=%0d last=%0b want all 0", fv1, fd1, ov1, fi1, fl1);
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        data_valid = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 32; k++) mc[k] = 0;
        model_zero_state();
    endtask

    task automatic test_impulse();
        rec_t e, o;
        int   t_imp;
        step(1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 32; k++) load0(k, k * 32'h1000);
        expq.delete(); obs0.delete();
        for (int i = 0; i < 31; i++) step(1'b1, 16'h0, 1'b0);
        step(1'b1, 16'h0100, 1'b0);
        t_imp = cyc;
        for (int i = 0; i < 31; i++) step(1'b1, 16'h0, 1'b0);
        idle(3);
        checks++;
        if (obs0.size() != 32 || expq.size() != 32) begin
            fails++;
            $display("FAIL impulse_count got %0d outputs (model %0d) want 32", obs0.size(), expq.size());
        end
        for (int i = 0; i < 32 && obs0.size() > 0 && expq.size() > 0; i++) begin
            e = expq.pop_front();
            o = obs0.pop_front();
            checks++;
            if (o.d !== 16'(i * 16) || o.d !== e.d || o.ov !== 1'b0 || o.t !== t_imp + 2 + i || o.fi !== e.fi) begin
                fails++;
                $display("FAIL impulse_out[%0d] got d=%h ovf=%0b t=%0d idx=%0d want d=%h ovf=0 t=%0d idx=%0d",
                         i, o.d, o.ov, o.t, o.fi, 16'(i * 16), t_imp + 2 + i, e.fi);
            end
        end
    endtask

    task automatic test_dc_sat();
        rec_t e, o;
        int   n;
        step(1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 32; k++) load0(k, 32'h10000);
        expq.delete(); obs0.delete();
        for (int i = 0; i < 36; i++) step(1'b1, 16'h7FFF, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 16'h8000, 1'b0);
        idle(3);
        checks++;
        if (obs0.size() != expq.size() || obs0.size() != 45) begin
            fail_count("dc_count", obs0.size(), 45);
        end
        n = obs0.size();
        for (int i = 0; i < n && expq.size() > 0; i++) begin
            e = expq.pop_front();
            o = obs0.pop_front();
            checks++;
            if (o.d !== e.d || o.ov !== e.ov || o.t !== e.t + 2
                || (i < 5 && (o.d !== 16'h7FFF || o.ov !== 1'b1))
                || (i == n - 1 && (o.d !== 16'h8000 || o.ov !== 1'b1))) begin
                fails++;
                $display("FAIL dc_sat_out[%0d] got d=%h ovf=%0b t=%0d want d=%h ovf=%0b t=%0d", i, o.d, o.ov, o.t, e.d, e.ov, e.t + 2);
            end
        end
    endtask

    task automatic fail_count(input string name, input int got, input int want);
        fails++;
        $display("FAIL %s got %0d want %0d", name, got, want);
    endtask

    task automatic test_framing();
        rec_t e, o;
        step(1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 32; k++) load0(k, int'($urandom_range(0, 4095)) - 2048);
        expq.delete(); obs0.delete();
        for (int i = 0; i < 71; i++) step(1'b1, 16'($urandom), 1'b0);
        idle(3);
        checks++;
        if (obs0.size() != 40) fail_count("frame_count", obs0.size(), 40);
        for (int i = 0; i < 40 && obs0.size() > 0 && expq.size() > 0; i++) begin
            e = expq.pop_front();
            o = obs0.pop_front();
            checks++;
            if (o.fi !== i % 16 || o.fl !== (i == 15 || i == 31) || o.d !== e.d || o.ov !== e.ov) begin
                fails++;
                $display("FAIL frame_out[%0d] got idx=%0d last=%0b d=%h want idx=%0d last=%0b d=%h",
                         i, o.fi, o.fl, o.d, i % 16, (i == 15 || i == 31), e.d);
            end
        end
    endtask

    task automatic test_gaps();
        rec_t e, o;
        int   n;
        step(1'b0, 16'h0, 1'b1);
        expq.delete(); obs0.delete();
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
        idle(3);
        checks++;
        if (obs0.size() != expq.size()) fail_count("gaps_count", obs0.size(), expq.size());
        n = obs0.size();
        for (int i = 0; i < n && expq.size() > 0; i++) begin
            e = expq.pop_front();
            o = obs0.pop_front();
            checks++;
            if (o.d !== e.d || o.ov !== e.ov || o.t !== e.t + 2 || o.fi !== e.fi || o.fl !== e.fl) begin
                fails++;
                $display("FAIL gaps_out[%0d] got d=%h ovf=%0b t=%0d idx=%0d want d=%h ovf=%0b t=%0d idx=%0d",
                         i, o.d, o.ov, o.t, o.fi, e.d, e.ov, e.t + 2, e.fi);
            end
        end
    endtask

    task automatic test_clear();
        rec_t e, o;
        int   n_before, n;
        step(1'b0, 16'h0, 1'b1);
        expq.delete(); obs0.delete();
        for (int i = 0; i < 50; i++) step(1'b1, 16'($urandom), 1'b0);
        step(1'b1, 16'h7777, 1'b1);
        n_before = obs0.size();
        for (int i = 0; i < 31; i++) step(1'b1, 16'($urandom), 1'b0);
        idle(2);
        checks++;
        if (obs0.size() != n_before) fail_count("clear_no_valid", obs0.size() - n_before, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0);
        idle(3);
        checks++;
        if (obs0.size() != expq.size()) fail_count("clear_count", obs0.size(), expq.size());
        n = obs0.size();
        for (int i = 0; i < n && expq.size() > 0; i++) begin
            e = expq.pop_front();
            o = obs0.pop_front();
            checks++;
            if (o.d !== e.d || o.ov !== e.ov || o.t !== e.t + 2 || o.fi !== e.fi) begin
                fails++;
                $display("FAIL clear_out[%0d] got d=%h t=%0d idx=%0d want d=%h t=%0d idx=%0d", i, o.d, o.t, o.fi, e.d, e.t + 2, e.fi);
            end
        end
    endtask

    task automatic test_rst_mid();
        rec_t e, o;
        int   n;
        expq.delete(); obs0.delete();
        for (int i = 0; i < 50; i++) step(1'b1, 16'($urandom), 1'b0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fv0 !== 1'b0 || fd0 !== 16'h0 || ov0 !== 1'b0 || fi0 !== 4'h0 || fl0 !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid_out got v=%0b d=%h ovf=%0b idx=%0d last=%0b want all 0", fv0, fd0, ov0, fi0, fl0);
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        rst = 1'b1;
        while (expq.size() > 0 && expq[$].t >= cyc - 4) void'(expq.pop_back());
        for (int k = 0; k < 32; k++) mc[k] = 0;
        model_zero_state();
        n = obs0.size();
        for (int i = 0; i < 41; i++) step(1'b1, 16'($urandom_range(1, 65535)), 1'b0);
        idle(3);
        checks++;
        if (obs0.size() - n != 10) fail_count("rst_mid_count", obs0.size() - n, 10);
        n = obs0.size();
        for (int i = 0; i < n && expq.size() > 0; i++) begin
            e = expq.pop_front();
            o = obs0.pop_front();
            checks++;
            if (o.d !== e.d || o.t !== e.t + 2 || (i >= n - 10 && (o.d !== 16'h0 || o.fi !== i - (n - 10)))) begin
                fails++;
                $display("FAIL rst_mid_out[%0d] got d=%h t=%0d idx=%0d want d=%h t=%0d", i, o.d, o.t, o.fi, e.d, e.t + 2);
            end
        end
    endtask

    task automatic test_sym();
        rec_t e, o, p;
        int   v;
        step(1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            v = int'($urandom_range(0, 32767)) - 16384;
            wr(1'b1, k, v);
            load0(k, v);
            load0(31 - k, v);
        end
        expq.delete(); obs0.delete(); obs1.delete();
        for (int i = 0; i < 61; i++) step(1'b1, 16'($urandom), 1'b0);
        idle(3);
        checks++;
        if (obs1.size() != 30 || obs0.size() != 30) fail_count("sym_count", obs1.size(), 30);
        for (int i = 0; i < 30 && expq.size() > 0 && obs0.size() > 0 && obs1.size() > 0; i++) begin
            e = expq.pop_front();
            o = obs0.pop_front();
            p = obs1.pop_front();
            checks++;
            if (p.d !== e.d || p.ov !== e.ov || p.t !== e.t + 2 || o.d !== e.d || o.ov !== e.ov) begin
                fails++;
                $display("FAIL sym_out[%0d] got sym d=%h ovf=%0b t=%0d full d=%h want d=%h ovf=%0b t=%0d",
                         i, p.d, p.ov, p.t, o.d, e.d, e.ov, e.t + 2);
            end
        end
    endtask

    initial begin
        checks = 0; fails = 0; cyc = 0;
        rst = 1'b0; clear = 1'b0; data_valid = 1'b0; data = '0;
        coef_we = 1'b0; coef_we_s = 1'b0; coef_addr = '0; coef_addr_s = '0; coef_wdata = '0;
        for (int k = 0; k < 32; k++) mc[k] = 0;
        model_zero_state();
        test_reset();
        test_impulse();
        test_dc_sat();
        test_framing();
        test_gaps();
        test_clear();
        test_rst_mid();
        test_sym();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
